// File: rtl/block_serial_carry_skip_subtractor.sv
// ----------------------------------------------------------------------------
// block_serial_carry_skip_subtractor
//
// Multi-cycle subtractor: diff = a - b - bin, evaluated one BLOCK_SIZE-bit
// slice per clock, LSB slice first. Internally the subtraction is done as
// a + ~b + ~bin, so the running carry c starts at ~bin and bout = ~carry_out.
// Each block uses carry-skip partitioning: when every real bit of the block
// propagates (a_i == b_i), the block carry-out is taken straight from the
// block carry-in and skip_cnt counts the block. The skip and ripple paths are
// bit-identical; skip only affects skip_cnt.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (aborts any operation)
//   in_valid   operand request; accepted when in_ready (IDLE only)
//   in_ready   high only in IDLE
//   a, b, bin  minuend, subtrahend, borrow in (captured at accept)
//   out_valid  result valid; held until out_ready
//   out_ready  result accepted (ignored outside DONE)
//   diff       difference mod 2^N (meaningful only while out_valid)
//   bout       borrow out, 1 when a < b + bin
//   busy       high in RUN or DONE
//   skip_cnt   number of blocks whose carry took the skip path
// ----------------------------------------------------------------------------

// One bit of the a + ~b chain: propagate, sum and carry-out.
module bscs_cell (
    input  logic a,
    input  logic nb,
    input  logic ci,
    output logic s,
    output logic p,
    output logic co
);
    assign p  = a ^ nb;
    assign s  = p ^ ci;
    assign co = (a & nb) | (p & ci);
endmodule

module block_serial_carry_skip_subtractor #(
    parameter int N          = 8,
    parameter int BLOCK_SIZE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         a,
    input  logic [N-1:0]         b,
    input  logic                 bin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         diff,
    output logic                 bout,
    output logic                 busy,
    output logic [$clog2((N + BLOCK_SIZE - 1) / BLOCK_SIZE + 1)-1:0] skip_cnt
);

    localparam int NB = (N + BLOCK_SIZE - 1) / BLOCK_SIZE;
    localparam int PW = NB * BLOCK_SIZE;
    // Wide enough to hold NB itself, so blk and skip_cnt share the width.
    localparam int CW = $clog2(NB + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [N-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic            c;      // running carry; holds ~bin before block 0
    logic [CW-1:0]   blk;

    // ------------------------------------------------------------------
    // Slice selection. Operands are zero-padded up to whole blocks; a pad
    // bit then has a=0, ~b=1, so it propagates and never generates. That
    // lets a partial last block use the same cell chain and the same
    // all-propagate skip test while only its real bits decide the result.
    // ------------------------------------------------------------------
    logic [PW-1:0]                a_pad;
    logic [PW-1:0]                b_pad;
    logic [NB-1:0][BLOCK_SIZE-1:0] a_blk;
    logic [NB-1:0][BLOCK_SIZE-1:0] b_blk;
    logic [NB:0][BLOCK_SIZE-1:0]   a_acc;
    logic [NB:0][BLOCK_SIZE-1:0]   b_acc;
    logic [BLOCK_SIZE-1:0]         a_sl;
    logic [BLOCK_SIZE-1:0]         nb_sl;

    always_comb begin
        a_pad        = '0;
        b_pad        = '0;
        a_pad[N-1:0] = a_q;
        b_pad[N-1:0] = b_q;
    end

    assign a_blk    = a_pad;
    assign b_blk    = b_pad;
    assign a_acc[0] = '0;
    assign b_acc[0] = '0;

    // AND-OR mux over blocks keyed on blk.
    for (genvar k = 0; k < NB; k++) begin : g_sel
        logic hit;
        assign hit        = (blk == CW'(k));
        assign a_acc[k+1] = a_acc[k] | (hit ? a_blk[k] : '0);
        assign b_acc[k+1] = b_acc[k] | (hit ? b_blk[k] : '0);
    end

    assign a_sl  = a_acc[NB];
    assign nb_sl = ~b_acc[NB];

    // ------------------------------------------------------------------
    // Ripple chain for the current block.
    // ------------------------------------------------------------------
    logic [BLOCK_SIZE:0]   cc;
    logic [BLOCK_SIZE-1:0] s_sl;
    logic [BLOCK_SIZE-1:0] p_sl;
    logic                  skip;
    logic                  blk_co;
    logic                  last;
    logic [N-1:0]          diff_nxt;

    assign cc[0] = c;

    for (genvar j = 0; j < BLOCK_SIZE; j++) begin : g_cell
        bscs_cell u_cell (
            .a  (a_sl[j]),
            .nb (nb_sl[j]),
            .ci (cc[j]),
            .s  (s_sl[j]),
            .p  (p_sl[j]),
            .co (cc[j+1])
        );
    end

    assign skip   = &p_sl;
    assign blk_co = skip ? c : cc[BLOCK_SIZE];
    assign last   = (blk == CW'(NB - 1));

    // Only the bits of the block being processed change; others hold.
    for (genvar gi = 0; gi < N; gi++) begin : g_diff
        assign diff_nxt[gi] = (blk == CW'(gi / BLOCK_SIZE)) ? s_sl[gi % BLOCK_SIZE]
                                                          : diff[gi];
    end

    // ------------------------------------------------------------------
    // Control FSM with registered handshake outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            skip_cnt  <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c         <= 1'b0;
            blk       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        // bin is folded into the initial carry.
                        a_q      <= a;
                        b_q      <= b;
                        c        <= ~bin;
                        blk      <= '0;
                        skip_cnt <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    diff <= diff_nxt;
                    c    <= blk_co;
                    blk  <= blk + CW'(1);
                    if (skip)
                        skip_cnt <= skip_cnt + CW'(1);
                    if (last) begin
                        bout      <= ~blk_co;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
